// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: instruction word/address widths shared with the datapath imem,
// plus the loader state encoding.
package prog_loader_pkg;

    localparam int PL_DATA_W = 21;
    localparam int PL_ADDR_W = 6;
    localparam int PL_DEPTH  = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CHK  = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams a host image into imem from address 0 and holds the CPU in reset
// until a clean load completes; PROG_LOADER_CHECKSUM_EN adds a trailing checksum word.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = PL_DATA_W,
    parameter int ADDR_W = PL_ADDR_W,
    parameter int DEPTH  = PL_DEPTH
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] WC_ONE = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                hs;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    assign hs = in_valid_i && in_ready_q;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wc_d    = wc_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start_i) begin
                    state_d = LOAD;
                    wc_d    = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    if (wc_q == FULL) begin
                        state_d = ERR;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = in_data_i;
                        wc_d    = wc_q + WC_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + in_data_i;
                        state_d = in_last_i ? CHK : LOAD;
`else
                        state_d = in_last_i ? RUN : LOAD;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (hs) state_d = (in_data_i == sum_q) ? RUN : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == LOAD) || (state_d == CHK);
        // Release only once RUN has been held a full cycle, so the last imem write lands first.
        cpu_reset_d = !((state_q == RUN) && (state_d == RUN));
        done_d      = !cpu_reset_d;
        error_d     = state_d == ERR;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wc_q        <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wc_q        <= wc_d;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sum_q <= '0;
        else         sum_q <= sum_d;
    end
`endif

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized image loads checked against an image-level model of the loader.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int DW = PL_DATA_W;
    localparam int AW = PL_ADDR_W;
    localparam int DEPTH = PL_DEPTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, imem_we, cpu_reset, done, error;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [AW:0]   word_count;

    prog_loader dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .cpu_reset_o(cpu_reset), .done_o(done), .error_o(error), .word_count_o(word_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] img[$];
    typedef struct {int addr; int data;} wr_t;
    wr_t wlog[$];

    always @(negedge clk) if (imem_we) wlog.push_back('{int'(imem_addr), int'(imem_wdata)});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit l, input bit gap);
        int k = 0;
        if (gap) begin
            in_valid = 1'b0;
            in_data = DW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = DW'($urandom);
    endtask

    // Loads img; the model: min(n,DEPTH) words land at 0.., overflow or bad checksum -> error.
    task automatic do_load(input bit last, input bit gap, input bit bad_sum);
        int n = img.size();
        int nw = (n > DEPTH) ? DEPTH : n;
        bit ovf = n > DEPTH;
        bit good;
        longint s = 0;
        wlog.delete();
        pulse_start();
        chk("start_ready", in_ready, 1);
        chk("start_wc", word_count, 0);
        chk("start_cpu_reset", cpu_reset, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        foreach (img[i]) begin
            send(img[i], last && (i == n - 1), gap);
            s = (s + longint'(img[i])) % (longint'(1) << DW);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        good = !ovf && !bad_sum;
        if (!ovf) begin
            send(bad_sum ? DW'((s + 1) % (longint'(1) << DW)) : DW'(s), bit'($urandom_range(0, 1)), gap);
            chk("sum_no_write", imem_we, 0);
        end
`else
        good = !ovf && !bad_sum;
        if (!ovf) begin
            chk("last_we", imem_we, 1);
            chk("last_addr", imem_addr, n - 1);
            chk("last_data", imem_wdata, img[n-1]);
        end
`endif
        if (ovf) chk("ovf_no_write", imem_we, 0);
        chk("hold_cpu_reset", cpu_reset, 1);
        chk("hold_done", done, 0);
        chk("early_error", error, !good);
        @(posedge clk); #1;
        chk("done", done, good);
        chk("cpu_reset", cpu_reset, !good);
        chk("error", error, !good);
        chk("ready_off", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("word_count", word_count, nw);
        chk("n_writes", wlog.size(), nw);
        for (int i = 0; i < nw && i < wlog.size(); i++) begin
            chk("wr_addr", wlog[i].addr, i);
            chk("wr_data", wlog[i].data, img[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wc", word_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 0);

        img = '{21'h1ABCD, 21'h00001, 21'h1FFFF};
        do_load(1, 0, 0);

        img.delete();
        repeat (5) img.push_back(DW'($urandom));
        do_load(1, 1, 0);

        img.delete();
        repeat (DEPTH + 1) img.push_back(DW'($urandom));
        do_load(0, 0, 0);

        img.delete();
        repeat (DEPTH) img.push_back(DW'($urandom));
        do_load(1, 0, 0);

        pulse_start();
        send(DW'($urandom), 0, 0);
        send(DW'($urandom), 0, 0);
        reset = 1'b1;
        #1;
        chk("abort_ready", in_ready, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_wc", word_count, 0);
        chk("abort_we", imem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_ready", in_ready, 0);
        img = '{DW'($urandom)};
        do_load(1, 0, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        img = '{21'h00005, 21'h00007};
        do_load(1, 0, 0);
        do_load(1, 0, 1);
        img = '{21'h1FFFFF, 21'h000002};
        do_load(1, 1, 0);
`endif

        for (int r = 0; r < 6; r++) begin
            img.delete();
            repeat ($urandom_range(1, DEPTH)) img.push_back(DW'($urandom));
`ifdef PROG_LOADER_CHECKSUM_EN
            do_load(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
`else
            do_load(1, bit'($urandom_range(0, 1)), 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
